instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq.sv | 128 ++++++++++++
 tb/tb_instr_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_seq.sv
// instr_seq: multi-cycle instruction sequencer for a simple datapath.
// It steps through FETCH/EXEC/(MEM)/WB for each instruction and keeps the
// program counter. It also gates the register-file and data-memory write
// enables so that each one fires only in its own phase.
// Optional build macro INSTR_SEQ_CYCLE_CNT_EN adds a 16-bit saturating
// CycleCnt output, which counts the busy cycles of the current program run.
module instr_seq #(
  parameter int unsigned          PC_W    = 10,
  parameter logic [PC_W-1:0]      LAST_PC = 10'h3FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Zero,
  input  logic            LS,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            IrLoad,
  output logic            RegWrEn,
  output logic            MemWrEn,
  output logic            Busy,
  output logic            Done
`ifdef INSTR_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]     CycleCnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} state_t;

  state_t state;
  logic   regwrite_q;
  logic   taken;

  // Redirect decision for the instruction that is retiring in WB.
  always_comb begin
    taken = Jump | (Branch & Zero);
  end

  // Sequencer FSM. All outputs are registered and are set on entry to the
  // state that owns them.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      IrLoad     <= 1'b0;
      RegWrEn    <= 1'b0;
      MemWrEn    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      IrLoad  <= 1'b0;
      RegWrEn <= 1'b0;
      MemWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= FETCH;
            ProgCtr <= '0;
            IrLoad  <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          // RegWrite is latched here so that a load still writes back in WB,
          // one cycle after MEM.
          regwrite_q <= RegWrite;
          if (LS | MemWrite) begin
            state   <= MEM;
            MemWrEn <= MemWrite;
          end else begin
            state   <= WB;
            RegWrEn <= RegWrite;
          end
        end
        MEM: begin
          state   <= WB;
          RegWrEn <= regwrite_q;
        end
        WB: begin
          if (taken) begin
            ProgCtr <= Target;
            state   <= FETCH;
            IrLoad  <= 1'b1;
          end else if (ProgCtr == LAST_PC) begin
            state <= HALT;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            ProgCtr <= ProgCtr + 1'b1;
            state   <= FETCH;
            IrLoad  <= 1'b1;
          end
        end
        HALT: begin
          if (!Start) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter. It clears when a run starts, saturates at its
  // maximum, and holds its value once the program halts.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      CycleCnt <= '0;
    end else if (state == IDLE && Start) begin
      CycleCnt <= '0;
    end else if (Busy && CycleCnt != '1) begin
      CycleCnt <= CycleCnt + 16'd1;
    end
  end
`else
  // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: scoreboard bench for instr_seq. For each instruction it
// drives, it pushes the expected retirement behaviour onto a queue. When
// the instruction retires, it pops that entry and compares it with the
// DUT outputs.
module tb_instr_seq;

  localparam int unsigned     PC_W = 10;
  localparam logic [PC_W-1:0] LAST = 10'd2;

  logic            Clk, Reset, Start, Branch, Jump, Zero, LS, MemWrite, RegWrite;
  logic [PC_W-1:0] Target, ProgCtr;
  logic            IrLoad, RegWrEn, MemWrEn, Busy, Done;
`ifdef INSTR_SEQ_CYCLE_CNT_EN
  logic [15:0]     CycleCnt;
`endif

  instr_seq #(.PC_W(PC_W), .LAST_PC(LAST)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Jump(Jump),
    .Zero(Zero), .LS(LS), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .Target(Target), .ProgCtr(ProgCtr), .IrLoad(IrLoad), .RegWrEn(RegWrEn),
    .MemWrEn(MemWrEn), .Busy(Busy), .Done(Done)
`ifdef INSTR_SEQ_CYCLE_CNT_EN
    , .CycleCnt(CycleCnt)
`endif
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] nxt;
    logic            halt;
    int unsigned     cycles;
    int unsigned     regwr;
    int unsigned     memwr;
    int unsigned     mem_cyc;
  } exp_t;

  exp_t            sb[$];
  logic [PC_W-1:0] model_pc;
  int unsigned     n_vec, n_err, ncyc;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) ncyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise Start at a negedge, then return at the negedge of the first FETCH.
  task automatic start_prog(output int unsigned c0);
    @(negedge Clk);
    Start = 1'b1;
    c0 = ncyc;
    @(negedge Clk);
    check("start_pc", ProgCtr, 0);
    check("start_irload", IrLoad, 1);
    check("start_busy", Busy, 1);
    model_pc = '0;
  endtask

  // Precondition: called at the negedge of a FETCH cycle.
  task automatic do_instr(input string tag, input logic br, input logic jmp, input logic z,
                          input logic ls, input logic mw, input logic rw,
                          input logic [PC_W-1:0] tgt);
    exp_t        e;
    logic        tk;
    logic [PC_W-1:0] g_pc;
    int unsigned g_cyc, g_rw, g_mw, g_mc;
    tk        = jmp | (br & z);
    e.pc      = model_pc;
    e.halt    = (model_pc == LAST) && !tk;
    e.nxt     = tk ? tgt : (e.halt ? model_pc : model_pc + 10'd1);
    e.cycles  = (ls | mw) ? 4 : 3;
    e.regwr   = rw ? 1 : 0;
    e.memwr   = mw ? 1 : 0;
    e.mem_cyc = mw ? 3 : 0;
    Branch = br; Jump = jmp; Zero = z; LS = ls; MemWrite = mw; RegWrite = rw; Target = tgt;
    sb.push_back(e);
    g_pc = ProgCtr; g_cyc = 0; g_rw = 0; g_mw = 0; g_mc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      g_cyc++;
      if (RegWrEn) g_rw++;
      if (MemWrEn) begin g_mw++; g_mc = g_cyc + 1; end
      if (IrLoad || Done) break;
    end
    e = sb.pop_front();
    check({tag, "_pc"}, g_pc, e.pc);
    check({tag, "_cycles"}, g_cyc, e.cycles);
    check({tag, "_regwr"}, g_rw, e.regwr);
    check({tag, "_memwr"}, g_mw, e.memwr);
    check({tag, "_memcyc"}, g_mc, e.mem_cyc);
    check({tag, "_next"}, ProgCtr, e.nxt);
    check({tag, "_done"}, Done, e.halt);
    model_pc = e.nxt;
  endtask

  initial begin
    int unsigned c0;
    n_vec = 0; n_err = 0;
    Start = 0; Branch = 0; Jump = 0; Zero = 0; LS = 0; MemWrite = 0; RegWrite = 0;
    Target = '0; model_pc = '0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    @(negedge Clk); @(negedge Clk);
    check("rst_pc", ProgCtr, 0);
    check("rst_irload", IrLoad, 0);
    check("rst_regwr", RegWrEn, 0);
    check("rst_memwr", MemWrEn, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b1;

    // Program A: three register-writing ALU instructions ending at LAST.
    start_prog(c0);
    do_instr("a0", 0, 0, 0, 0, 0, 1, 10'd0);
    do_instr("a1", 0, 0, 0, 0, 0, 1, 10'd0);
    do_instr("a2", 0, 0, 0, 0, 0, 1, 10'd0);
    check("a_done_cycle", ncyc - c0, 10);
`ifdef INSTR_SEQ_CYCLE_CNT_EN
    check("a_cyclecnt", CycleCnt, 9);
`endif
    @(negedge Clk);
    check("halt_hold_done", Done, 1);
    check("halt_hold_busy", Busy, 0);
    Start = 1'b0;
    @(negedge Clk);
    check("idle_done", Done, 0);
    check("idle_busy", Busy, 0);

    // Program B: stores, branches, jumps, a self-loop and PC wrap.
    start_prog(c0);
    Start = 1'b0;
    do_instr("b_j5", 0, 1, 0, 0, 0, 0, 10'd5);
    Start = 1'b1;
    do_instr("b_st5", 0, 0, 0, 0, 1, 0, 10'd0);
    check("st_pc6", ProgCtr, 6);
    Start = 1'b0;
    do_instr("b_j7", 0, 1, 0, 0, 0, 0, 10'd7);
    do_instr("b_brnt", 1, 0, 0, 0, 0, 0, 10'd40);
    check("brnt_pc8", ProgCtr, 8);
    do_instr("b_j7b", 0, 1, 0, 0, 0, 0, 10'd7);
    Start = 1'b1;
    do_instr("b_brt", 1, 0, 1, 0, 0, 0, 10'd40);
    check("brt_pc40", ProgCtr, 40);
    do_instr("b_self", 0, 1, 0, 0, 0, 0, 10'd40);
    check("self_pc40", ProgCtr, 40);
    do_instr("b_j7c", 0, 1, 0, 0, 0, 0, 10'd7);
    do_instr("b_jmp", 0, 1, 0, 0, 0, 0, 10'd40);
    check("jmp_pc40", ProgCtr, 40);
    do_instr("b_j2", 0, 1, 1, 0, 0, 0, 10'd2);
    do_instr("b_jlast", 0, 1, 0, 0, 0, 0, 10'd0);
    check("jlast_pc0", ProgCtr, 0);
    check("jlast_busy", Busy, 1);
    do_instr("b_j1023", 0, 1, 0, 0, 0, 0, 10'd1023);
    do_instr("b_wrap", 0, 0, 0, 0, 0, 1, 10'd0);
    check("wrap_pc0", ProgCtr, 0);
    do_instr("b_j5b", 0, 1, 0, 0, 0, 0, 10'd5);
    do_instr("b_ld5", 0, 0, 0, 1, 0, 1, 10'd0);
    do_instr("b_j2b", 0, 1, 0, 0, 0, 0, 10'd2);
    Start = 1'b0;
    do_instr("b_end", 0, 0, 0, 0, 0, 0, 10'd0);
    @(negedge Clk);
    check("b_idle_done", Done, 0);

    // Asynchronous reset in the MEM cycle of a store.
    start_prog(c0);
    Start = 1'b0;
    Branch = 0; Jump = 0; Zero = 0; LS = 0; MemWrite = 1; RegWrite = 1;
    @(negedge Clk);
    @(negedge Clk);
    check("mr_memwr_pre", MemWrEn, 1);
    #2 Reset = 1'b0;
    #1;
    check("mr_memwr", MemWrEn, 0);
    check("mr_busy", Busy, 0);
    check("mr_done", Done, 0);
    check("mr_pc", ProgCtr, 0);
    @(negedge Clk);
    check("mr_regwr", RegWrEn, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check("mr_idle_busy", Busy, 0);
    check("mr_idle_irload", IrLoad, 0);
`ifdef INSTR_SEQ_CYCLE_CNT_EN
    check("mr_cyclecnt", CycleCnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
